// File: rtl/pbkdf2_pkg.sv
// Shared types and constants for the PBKDF2 engine: FSM state encoding and widths.
package pbkdf2_pkg;

    localparam int INT_W      = 32;
    localparam int HASH_W_DEF = 256;

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_DONE,
        S_DRAIN
    } state_e;

endpackage

// File: rtl/pbkdf2_if.sv
// PRF request/response channel between the PBKDF2 sequencer (master) and the HMAC core (slave).
interface pbkdf2_if #(
    parameter int PASS_W = 256,
    parameter int SALT_W = 256,
    parameter int HASH_W = 256
) ();

    logic                 req_v;
    logic                 req_ready;
    logic [PASS_W-1:0]    key;
    logic [SALT_W+31:0]   msg;
    logic                 first;
    logic                 rsp_v;
    logic                 rsp_ready;
    logic [HASH_W-1:0]    rsp_data;

    modport master (
        output req_v, key, msg, first, rsp_ready,
        input  req_ready, rsp_v, rsp_data
    );

    modport slave (
        input  req_v, key, msg, first, rsp_ready,
        output req_ready, rsp_v, rsp_data
    );

endinterface

// File: rtl/pbkdf2_block_acc.sv
// Per-block U/T accumulation: U tracks the last PRF output, T the running XOR, and the
// finished T is written into its derived-key slot (block 1 in the MSBs).
module pbkdf2_block_acc #(
    parameter int BLOCKS = 1,
    parameter int HASH_W = 256,
    parameter int I_W    = 1
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     capture_i,
    input  logic                     first_i,
    input  logic                     last_i,
    input  logic [I_W-1:0]           slot_i,
    input  logic [HASH_W-1:0]        data_i,
    output logic [HASH_W-1:0]        u_o,
    output logic [BLOCKS*HASH_W-1:0] dk_o
);

    logic [HASH_W-1:0]        u_q, u_d;
    logic [HASH_W-1:0]        acc_q, acc_d;
    logic [BLOCKS*HASH_W-1:0] dk_q, dk_d;

    always_comb begin
        u_d   = u_q;
        acc_d = acc_q;
        dk_d  = dk_q;
        if (capture_i) begin
            u_d   = data_i;
            acc_d = first_i ? data_i : (acc_q ^ data_i);
            if (last_i) begin
                for (int b = 0; b < BLOCKS; b++) begin
                    if (slot_i == I_W'(b + 1)) begin
                        dk_d[(BLOCKS-b)*HASH_W-1 -: HASH_W] = acc_d;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            u_q   <= '0;
            acc_q <= '0;
            dk_q  <= '0;
        end else begin
            u_q   <= u_d;
            acc_q <= acc_d;
            dk_q  <= dk_d;
        end
    end

    assign u_o  = u_q;
    assign dk_o = dk_q;

endmodule

// File: rtl/pbkdf2_core.sv
// PBKDF2 sequencer driving an external HMAC PRF; XORs each block's iterations into dk_o.
// Optional abort support (abort_i port, DRAIN state) is built when PBKDF2_ABORT_EN is defined.
module pbkdf2_core
    import pbkdf2_pkg::*;
#(
    parameter int BLOCKS = 1,
    parameter int HASH_W = HASH_W_DEF,
    parameter int PASS_W = 256,
    parameter int SALT_W = 256,
    parameter int ITER_W = 32
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
`ifdef PBKDF2_ABORT_EN
    input  logic                     abort_i,
`endif
    input  logic                     v_i,
    output logic                     ready_o,
    input  logic [PASS_W-1:0]        pass_i,
    input  logic [SALT_W-1:0]        salt_i,
    input  logic [ITER_W-1:0]        iters_i,
    pbkdf2_if.master                 prf,
    output logic                     v_o,
    input  logic                     ready_i,
    output logic [BLOCKS*HASH_W-1:0] dk_o
);

    localparam int I_W = $clog2(BLOCKS + 1);
    localparam logic [I_W-1:0]    I_ONE  = I_W'(1);
    localparam logic [I_W-1:0]    I_LAST = I_W'(BLOCKS);
    localparam logic [ITER_W-1:0] J_ONE  = ITER_W'(1);

    state_e              state_q, state_d;
    logic                ready_q;
    logic [I_W-1:0]      i_q, i_d;
    logic [ITER_W-1:0]   j_q, j_d;
    logic [ITER_W-1:0]   iters_q;
    logic [PASS_W-1:0]   pass_q;
    logic [SALT_W-1:0]   salt_q;
    logic                latch;
    logic                capture;
    logic                first_w;
    logic [HASH_W-1:0]   u_w;

    always_comb begin
        state_d = state_q;
        i_d     = i_q;
        j_d     = j_q;
        latch   = 1'b0;
        capture = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (v_i && ready_q) begin
                    latch   = 1'b1;
                    i_d     = I_ONE;
                    j_d     = J_ONE;
                    state_d = S_REQ;
                end
            end
            S_REQ: begin
                if (prf.req_ready) state_d = S_WAIT;
`ifdef PBKDF2_ABORT_EN
                if (abort_i) state_d = prf.req_ready ? S_DRAIN : S_IDLE;
`endif
            end
            S_WAIT: begin
                // j is compared against c before incrementing, so c = 2^ITER_W-1 cannot wrap
                if (prf.rsp_v) begin
                    capture = 1'b1;
                    if (j_q != iters_q) begin
                        j_d     = j_q + J_ONE;
                        state_d = S_REQ;
                    end else if (i_q == I_LAST) begin
                        state_d = S_DONE;
                    end else begin
                        i_d     = i_q + I_ONE;
                        j_d     = J_ONE;
                        state_d = S_REQ;
                    end
                end
`ifdef PBKDF2_ABORT_EN
                if (abort_i) begin
                    capture = 1'b0;
                    i_d     = i_q;
                    j_d     = j_q;
                    state_d = prf.rsp_v ? S_IDLE : S_DRAIN;
                end
`endif
            end
            S_DONE: begin
`ifdef PBKDF2_ABORT_EN
                if (ready_i || abort_i) state_d = S_IDLE;
`else
                if (ready_i) state_d = S_IDLE;
`endif
            end
`ifdef PBKDF2_ABORT_EN
            S_DRAIN: begin
                if (prf.rsp_v) state_d = S_IDLE;
            end
`endif
            default: state_d = S_IDLE;
        endcase
    end

    // ready_o is registered so it stays low through reset and rises one cycle after release
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            ready_q <= 1'b0;
            i_q     <= '0;
            j_q     <= '0;
            iters_q <= '0;
            pass_q  <= '0;
            salt_q  <= '0;
        end else begin
            state_q <= state_d;
            ready_q <= (state_d == S_IDLE);
            i_q     <= i_d;
            j_q     <= j_d;
            if (latch) begin
                pass_q  <= pass_i;
                salt_q  <= salt_i;
                iters_q <= (iters_i == '0) ? J_ONE : iters_i;
            end
        end
    end

    assign first_w       = (j_q == J_ONE);
    assign ready_o       = ready_q;
    assign v_o           = (state_q == S_DONE);
    assign prf.req_v     = (state_q == S_REQ);
    assign prf.rsp_ready = (state_q == S_WAIT) || (state_q == S_DRAIN);
    assign prf.first     = first_w;
    assign prf.key       = pass_q;
    assign prf.msg       = first_w ? {salt_q, INT_W'(i_q)} : (SALT_W + INT_W)'(u_w);

    pbkdf2_block_acc #(
        .BLOCKS (BLOCKS),
        .HASH_W (HASH_W),
        .I_W    (I_W)
    ) u_acc (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .capture_i (capture),
        .first_i   (first_w),
        .last_i    (j_q == iters_q),
        .slot_i    (i_q),
        .data_i    (prf.rsp_data),
        .u_o       (u_w),
        .dk_o      (dk_o)
    );

endmodule

// File: tb/tb_pbkdf2_core.sv
// Bench for pbkdf2_core (BLOCKS=2) with a mock PRF returning msg[HASH_W-1:0]+1;
// expected keys come from a block/iteration loop model and are checked by a scoreboard monitor.
module tb_pbkdf2_core;
    import pbkdf2_pkg::*;

    localparam int BLOCKS = 2;
    localparam int HASH_W = 256;
    localparam int PASS_W = 256;
    localparam int SALT_W = 256;
    localparam int ITER_W = 32;
    localparam int DK_W   = BLOCKS * HASH_W;

    typedef struct {
        logic [DK_W-1:0] dk;
        int              acc_cyc;
        int              lat;
    } exp_t;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              v_i = 1'b0;
    logic              ready_o;
    logic [PASS_W-1:0] pass_i = '0;
    logic [SALT_W-1:0] salt_i = '0;
    logic [ITER_W-1:0] iters_i = '0;
    logic              v_o;
    logic              ready_i = 1'b1;
    logic [DK_W-1:0]   dk_o;
`ifdef PBKDF2_ABORT_EN
    logic              abort_i = 1'b0;
`endif

    logic              hold_req = 1'b0;
    int                rsp_delay = 0;
    logic              pend;
    int                dcnt;
    logic [HASH_W-1:0] pend_data;

    int   cyc = 0;
    int   n_pass = 0;
    int   n_total = 0;
    exp_t sb[$];

    pbkdf2_if #(.PASS_W(PASS_W), .SALT_W(SALT_W), .HASH_W(HASH_W)) prf_if ();

    pbkdf2_core #(
        .BLOCKS (BLOCKS),
        .HASH_W (HASH_W),
        .PASS_W (PASS_W),
        .SALT_W (SALT_W),
        .ITER_W (ITER_W)
    ) dut (
        .clk_i   (clk),
        .rst_i   (rst),
`ifdef PBKDF2_ABORT_EN
        .abort_i (abort_i),
`endif
        .v_i     (v_i),
        .ready_o (ready_o),
        .pass_i  (pass_i),
        .salt_i  (salt_i),
        .iters_i (iters_i),
        .prf     (prf_if),
        .v_o     (v_o),
        .ready_i (ready_i),
        .dk_o    (dk_o)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Mock PRF: response = low HASH_W bits of the message plus one, after rsp_delay extra cycles
    assign prf_if.req_ready = !hold_req;
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            prf_if.rsp_v    <= 1'b0;
            prf_if.rsp_data <= '0;
            pend            <= 1'b0;
            dcnt            <= 0;
            pend_data       <= '0;
        end else begin
            if (prf_if.rsp_v && prf_if.rsp_ready) prf_if.rsp_v <= 1'b0;
            if (pend) begin
                if (dcnt == 0) begin
                    prf_if.rsp_v    <= 1'b1;
                    prf_if.rsp_data <= pend_data;
                    pend            <= 1'b0;
                end else begin
                    dcnt <= dcnt - 1;
                end
            end
            if (prf_if.req_v && prf_if.req_ready) begin
                if (rsp_delay == 0) begin
                    prf_if.rsp_v    <= 1'b1;
                    prf_if.rsp_data <= prf_if.msg[HASH_W-1:0] + 1'b1;
                end else begin
                    pend      <= 1'b1;
                    dcnt      <= rsp_delay - 1;
                    pend_data <= prf_if.msg[HASH_W-1:0] + 1'b1;
                end
            end
        end
    end

    task automatic check(input string name, input logic [DK_W-1:0] act, input logic [DK_W-1:0] req);
        n_total++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %0h, required %0h", name, act, req);
    endtask

    // T_i = U_1 ^ ... ^ U_c, where U_1 = PRF(salt || INT(i)) and U_k = PRF(U_{k-1}) = U_{k-1}+1
    function automatic logic [DK_W-1:0] model_dk(input logic [SALT_W-1:0] salt,
                                                 input logic [ITER_W-1:0] c_in);
        logic [DK_W-1:0]     dk;
        logic [HASH_W-1:0]   u;
        logic [HASH_W-1:0]   t;
        logic [SALT_W+31:0]  m;
        longint              c;
        dk = '0;
        c  = (c_in == 0) ? 1 : longint'(c_in);
        for (int blk = 1; blk <= BLOCKS; blk++) begin
            m = {salt, 32'(blk)};
            u = m[HASH_W-1:0] + 1'b1;
            t = u;
            for (longint k = 2; k <= c; k++) begin
                u = u + 1'b1;
                t = t ^ u;
            end
            dk[(BLOCKS-blk+1)*HASH_W-1 -: HASH_W] = t;
        end
        return dk;
    endfunction

    function automatic logic [255:0] rnd256();
        logic [255:0] r;
        for (int k = 0; k < 8; k++) r[k*32 +: 32] = $urandom;
        return r;
    endfunction

    // Scoreboard monitor: latency on v_o rise, key compare on output handshake
    logic v_prev = 1'b0;
    always @(negedge clk) begin
        if (rst) begin
            v_prev <= 1'b0;
        end else begin
            if (v_o && !v_prev) begin
                if (sb.size() == 0) check("unexpected_v_o", DK_W'(v_o), DK_W'(0));
                else if (sb[0].lat >= 0)
                    check("latency", DK_W'(cyc - sb[0].acc_cyc), DK_W'(sb[0].lat));
            end
            if (v_o && ready_i && sb.size() > 0) check("dk", dk_o, sb.pop_front().dk);
            v_prev <= v_o;
        end
    end

    // Stability of the stalled request and of the held key output
    logic            pstall = 1'b0;
    logic            pdone = 1'b0;
    logic [SALT_W+31:0] pmsg = '0;
    logic [PASS_W-1:0]  pkey = '0;
    logic [DK_W-1:0]    pdk = '0;
    always @(negedge clk) begin
        if (rst) begin
            pstall <= 1'b0;
            pdone  <= 1'b0;
        end else begin
            if (pstall) begin
                check("req_hold_v", DK_W'(prf_if.req_v), DK_W'(1));
                check("req_hold_msg", DK_W'(prf_if.msg), DK_W'(pmsg));
                check("req_hold_key", DK_W'(prf_if.key), DK_W'(pkey));
            end
            if (pdone) begin
                check("done_hold_v", DK_W'(v_o), DK_W'(1));
                check("done_hold_dk", dk_o, pdk);
            end
            pstall <= prf_if.req_v && !prf_if.req_ready;
            pdone  <= v_o && !ready_i;
            pmsg   <= prf_if.msg;
            pkey   <= prf_if.key;
            pdk    <= dk_o;
        end
    end

    task automatic run_job(input logic [PASS_W-1:0] p, input logic [SALT_W-1:0] s,
                           input logic [ITER_W-1:0] c, input bit push, input bit chk_lat);
        int   n;
        int   ce;
        exp_t e;
        @(negedge clk);
        v_i = 1'b1; pass_i = p; salt_i = s; iters_i = c;
        n = 0;
        while (!ready_o && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (!ready_o) begin
            check("accept_timeout", DK_W'(ready_o), DK_W'(1));
        end else begin
            ce = (c == 0) ? 1 : int'(c);
            e.dk      = model_dk(s, c);
            e.acc_cyc = cyc;
            e.lat     = chk_lat ? 2 * BLOCKS * ce + 1 : -1;
            if (push) sb.push_back(e);
        end
        @(posedge clk);
        #1 v_i = 1'b0;
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 5000) begin
            @(negedge clk);
            n++;
        end
        check("drain", DK_W'(sb.size()), DK_W'(0));
    endtask

    initial begin
        #1 rst = 1'b1;
        #1;
        check("rst_ready_o", DK_W'(ready_o), DK_W'(0));
        check("rst_v_o", DK_W'(v_o), DK_W'(0));
        check("rst_prf_v_o", DK_W'(prf_if.req_v), DK_W'(0));
        check("rst_prf_ready_o", DK_W'(prf_if.rsp_ready), DK_W'(0));
        check("rst_prf_first_o", DK_W'(prf_if.first), DK_W'(0));
        check("rst_dk_o", dk_o, DK_W'(0));
        check("rst_prf_msg_o", DK_W'(prf_if.msg), DK_W'(0));
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1 check("ready_low_at_release", DK_W'(ready_o), DK_W'(0));
        @(negedge clk);
        check("ready_after_release", DK_W'(ready_o), DK_W'(1));

        // Directed: salt=0 with c=1, c=3 and c=0 (treated as 1)
        run_job(rnd256(), '0, 1, 1'b1, 1'b1);
        wait_drain();
        run_job(rnd256(), '0, 3, 1'b1, 1'b1);
        wait_drain();
        run_job(rnd256(), '0, 0, 1'b1, 1'b1);
        wait_drain();

        // Request stall for 5 cycles, then output stall for 4 cycles
        @(posedge clk); #1 hold_req = 1'b1; ready_i = 1'b0;
        run_job(rnd256(), rnd256(), 2, 1'b1, 1'b0);
        repeat (5) @(negedge clk);
        @(posedge clk); #1 hold_req = 1'b0;
        begin
            int n;
            n = 0;
            while (!v_o && n < 200) begin
                @(negedge clk);
                n++;
            end
            check("stall_v_o", DK_W'(v_o), DK_W'(1));
        end
        repeat (4) @(negedge clk);
        @(posedge clk); #1 ready_i = 1'b1;
        wait_drain();

        // Back-to-back random jobs
        for (int k = 0; k < 8; k++) begin
            run_job(rnd256(), rnd256(), ITER_W'($urandom_range(0, 5)), 1'b1, 1'b1);
        end
        wait_drain();

`ifdef PBKDF2_ABORT_EN
        // Abort while waiting on a slow response
        rsp_delay = 4;
        run_job(rnd256(), rnd256(), 3, 1'b0, 1'b0);
        begin
            int n;
            n = 0;
            while (!prf_if.rsp_ready && n < 50) begin
                @(negedge clk);
                n++;
            end
            abort_i = 1'b1;
            @(posedge clk); #1 abort_i = 1'b0;
            n = 0;
            @(negedge clk);
            while (!(prf_if.rsp_v && prf_if.rsp_ready) && n < 50) begin
                @(negedge clk);
                n++;
            end
            check("abort_rsp_seen", DK_W'(prf_if.rsp_v && prf_if.rsp_ready), DK_W'(1));
            @(negedge clk);
            check("abort_ready_o", DK_W'(ready_o), DK_W'(1));
            check("abort_v_o", DK_W'(v_o), DK_W'(0));
        end
        rsp_delay = 0;
        run_job(rnd256(), rnd256(), 2, 1'b1, 1'b1);
        wait_drain();
`endif

        // Asynchronous reset while a request is stalled
        @(posedge clk); #1 hold_req = 1'b1;
        run_job(rnd256(), rnd256(), 4, 1'b1, 1'b0);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("arst_prf_v_o", DK_W'(prf_if.req_v), DK_W'(0));
        check("arst_ready_o", DK_W'(ready_o), DK_W'(0));
        check("arst_v_o", DK_W'(v_o), DK_W'(0));
        check("arst_prf_key_o", DK_W'(prf_if.key), DK_W'(0));
        check("arst_prf_msg_o", DK_W'(prf_if.msg), DK_W'(0));
        check("arst_dk_o", dk_o, DK_W'(0));
        sb.delete();
        hold_req = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        run_job(rnd256(), rnd256(), 3, 1'b1, 1'b1);
        wait_drain();

        repeat (3) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d so far", n_pass, n_total);
        $fatal(1);
    end

endmodule

// File: doc/pbkdf2_core.md
# pbkdf2_core

Parametrised PBKDF2 (RFC 8018) key-derivation engine producing a BLOCKS×HASH_W-bit derived key from a password, salt and iteration count. It sequences an external HMAC PRF through valid/ready request and response channels and XOR-accumulates each block's iterations. It exposes a valid/ready job input and a valid/ready key output, and sits between the job front-end and the shared HMAC-SHA256 core.

## Interface
- BLOCKS, 1, derived-key blocks (dkLen = BLOCKS×HASH_W)
- HASH_W, 256, PRF output width
- PASS_W, 256, password width
- SALT_W, 256, salt width
- ITER_W, 32, iteration-count width
- clk_i  in  1  clock
- rst_i  in  1  reset, asynchronous, active-high
- v_i  in  1  job valid
- ready_o  out  1  job accepted when v_i&&ready_o
- pass_i  in  PASS_W  password
- salt_i  in  SALT_W  salt
- iters_i  in  ITER_W  iteration count c
- prf_v_o  out  1  PRF request valid
- prf_ready_i  in  1  PRF accepts request
- prf_key_o  out  PASS_W  PRF key (latched password)
- prf_msg_o  out  SALT_W+32  PRF message
- prf_first_o  out  1  1: message is salt‖INT(i); 0: previous U in low HASH_W bits, zero-extended
- prf_v_i  in  1  PRF response valid
- prf_ready_o  out  1  response accepted when prf_v_i&&prf_ready_o
- prf_data_i  in  HASH_W  PRF output
- v_o  out  1  derived key valid
- ready_i  in  1  consumer accepts key
- dk_o  out  BLOCKS×HASH_W  derived key; T1 in MSBs

## Operation
- States: IDLE, REQ, WAIT, DONE (plus DRAIN with abort).
- IDLE: ready_o=1. On v_i&&ready_o, latch pass/salt/iters, i=1, j=1 → REQ. iters_i==0 treated as 1.
- REQ: prf_v_o=1, msg held stable until prf_v_o&&prf_ready_i → WAIT. For j==1: prf_first_o=1, msg={salt, i as 32-bit big-endian}. Otherwise msg={32'b0, U}.
- WAIT: prf_ready_o=1. On prf_v_i: U←data; acc←(j==1)?data:acc^data.
  - j<c: j++ → REQ.
  - j==c: dk slot i (bits [(BLOCKS−i+1)·HASH_W−1 -: HASH_W]) ← final acc. If i==BLOCKS → DONE, else i++, j=1 → REQ.
- DONE: v_o=1, dk_o stable; on ready_i → IDLE.
- Counters: j is ITER_W bits, compared before increment, so there is no wrap at c=2^ITER_W−1. i is $clog2(BLOCKS+1) bits.
- prf_ready_o=0 outside WAIT/DRAIN. A response outside these states is a protocol error and is ignored.

## Timing
- Reset: ready_o, v_o, prf_v_o, prf_ready_o, prf_first_o = 0. dk_o, prf_key_o, prf_msg_o = 0. State IDLE. ready_o rises in the first cycle after reset deasserts.
- Reset mid-job discards all state. The PRF shares rst_i, so no orphan responses arise.
- Each PRF call takes at least 2 cycles (REQ accept, WAIT response).
- With a zero-wait PRF, v_o rises 2·BLOCKS·c+1 cycles after the acceptance edge.
- No new job is accepted until DONE handshakes. Back-to-back jobs: ready_o is high the cycle after the output handshake.
- Any number of stall cycles is legal on both PRF channels. prf_msg_o and prf_key_o hold while prf_v_o&&!prf_ready_i.

## Configuration
- PBKDF2_ABORT_EN defined: adds port abort_i (in, 1). abort_i is ignored in IDLE.
  - REQ: abort without a same-cycle handshake → IDLE. Abort with a same-cycle handshake → DRAIN.
  - WAIT: abort → DRAIN, unless prf_v_i is high that cycle, in which case → IDLE and the data is discarded.
  - DRAIN: prf_ready_o=1; discard one response → IDLE.
  - DONE: abort → IDLE with v_o dropped. If ready_i is also high, the transfer counts.
- Not defined: no port, no DRAIN state, abort logic absent.

## Structure
- pbkdf2_pkg holds: state enum (IDLE/REQ/WAIT/DONE/DRAIN), INT_W=32, default HASH_W.
- Sub-module pbkdf2_block_acc holds the U and acc registers, the XOR/first-select, and slot write to dk.

## Test plan
Mock PRF returns prf_msg_o[HASH_W-1:0]+1, zero wait states.
- BLOCKS=1, salt=0, c=1 → dk_o=2; v_o 3 cycles after acceptance.
- BLOCKS=2, salt=0, c=3 → T1=2^3^4=5, T2=3^4^5=2. dk_o={256'd5,256'd2}; v_o at cycle 13.
- c=0, BLOCKS=1 → identical to the c=1 case, dk_o=2.
- prf_ready_i low for 5 cycles in REQ → prf_v_o held, prf_msg_o unchanged. ready_i low for 4 cycles in DONE → dk_o stable. Result unchanged.
- With PBKDF2_ABORT_EN, abort in WAIT with the response delayed 4 cycles → response consumed, ready_o high the next cycle, v_o never asserted. The next job gives correct dk.
- rst_i asserted asynchronously mid-REQ → prf_v_o and all outputs 0 before the next clock edge. A post-reset job gives correct dk.
